// File: rtl/reg_anim_ctl_if.sv
// rtl/reg_anim_ctl_if.sv - control inputs and display outputs of the register-overlay animation controller
interface reg_anim_ctl_if #(
  parameter int NREG   = 4,
  parameter int REG_W  = 16,
  parameter int FCNT_W = 8,
  parameter int ZOOM_W = 3,
  parameter int POS_W  = 10
);
  localparam int SEL_W = (NREG > 1) ? $clog2(NREG) : 1;

  logic                  endframe;
  logic [1:0]            mode;
  logic                  zoom_hold;
  logic                  load_en;
  logic [SEL_W-1:0]      load_sel;
  logic [REG_W-1:0]      load_val;
  logic [3:0]            btn;
  logic [NREG*REG_W-1:0] registers;
  logic [ZOOM_W-1:0]     zoom;
  logic [POS_W-1:0]      x_pos;
  logic [POS_W-1:0]      y_pos;
  logic [FCNT_W-1:0]     frame_cnt;
  logic                  led;

  modport master (
    output endframe, mode, zoom_hold, load_en, load_sel, load_val, btn,
    input  registers, zoom, x_pos, y_pos, frame_cnt, led
  );

  modport slave (
    input  endframe, mode, zoom_hold, load_en, load_sel, load_val, btn,
    output registers, zoom, x_pos, y_pos, frame_cnt, led
  );
endinterface

// File: rtl/reg_anim_ctl.sv
// rtl/reg_anim_ctl.sv - frame-driven register animator with zoom ping-pong and button positions
module reg_anim_ctl #(
  parameter int              NREG          = 4,
  parameter int              REG_W         = 16,
  parameter logic [REG_W-1:0] REG_INIT     = 16'h0019,
  parameter int              FCNT_W        = 8,
  parameter int              REG_DIV_LOG2  = 4,
  parameter int              ZOOM_DIV_LOG2 = 7,
  parameter int              ZOOM_W        = 3,
  parameter int              ZOOM_MAX      = 4,
  parameter int              POS_W         = 10,
  parameter int              POS_MIN       = 0,
  parameter int              POS_MAX       = 639,
  parameter int              POS_STEP      = 4
) (
  input logic           px_clk,
  input logic           rst_n,
  reg_anim_ctl_if.slave bus
);
  localparam int SEL_W = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic {Z_UP, Z_DOWN} zoom_state_t;

  logic              endframe_q;
  logic [3:0]        btn_s1;
  logic [3:0]        btn_s2;
  logic [FCNT_W-1:0] fcnt_q;
  logic [REG_W-1:0]  reg_q [NREG];
  logic [POS_W-1:0]  x_q;
  logic [POS_W-1:0]  y_q;
  logic [ZOOM_W-1:0] zoom_q;
  logic [ZOOM_W-1:0] zoom_d;
  zoom_state_t       state_q;
  zoom_state_t       state_d;
  logic              frame_tick;
  logic              reg_tick;
  logic              zoom_tick;

  // endframe_q resets high so a level already high at reset release is not a tick
  assign frame_tick = bus.endframe & ~endframe_q;
  assign reg_tick   = frame_tick & (&fcnt_q[REG_DIV_LOG2-1:0]);
  assign zoom_tick  = frame_tick & (&fcnt_q[ZOOM_DIV_LOG2-1:0]);

  // Saturating step evaluated one bit wider so the top bound cannot wrap
  function automatic logic [POS_W-1:0] pos_next(input logic [POS_W-1:0] pos,
                                                input logic up, input logic down);
    logic [POS_W:0] wide;
    wide     = {1'b0, pos} + (POS_W+1)'(POS_STEP);
    pos_next = pos;
    if (up && !down) begin
      pos_next = (wide > (POS_W+1)'(POS_MAX)) ? POS_W'(POS_MAX) : wide[POS_W-1:0];
    end else if (down && !up) begin
      pos_next = ({1'b0, pos} < (POS_W+1)'(POS_MIN + POS_STEP)) ?
                 POS_W'(POS_MIN) : pos - POS_W'(POS_STEP);
    end
  endfunction

  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      endframe_q <= 1'b1;
      btn_s1     <= '0;
      btn_s2     <= '0;
      fcnt_q     <= '0;
      x_q        <= POS_W'(POS_MIN);
      y_q        <= POS_W'(POS_MIN);
    end else begin
      endframe_q <= bus.endframe;
      btn_s1     <= bus.btn;
      btn_s2     <= btn_s1;
      if (frame_tick) begin
        fcnt_q <= fcnt_q + 1'b1;
        x_q    <= pos_next(x_q, btn_s2[0], btn_s2[1]);
        y_q    <= pos_next(y_q, btn_s2[2], btn_s2[3]);
      end
    end
  end

  // An out-of-range load_sel never equals a channel index, so it is dropped
  for (genvar i = 0; i < NREG; i++) begin : g_reg
    always_ff @(posedge px_clk or negedge rst_n) begin
      if (!rst_n) begin
        reg_q[i] <= REG_INIT + REG_W'(i);
      end else if (bus.load_en && bus.load_sel == SEL_W'(i)) begin
        reg_q[i] <= bus.load_val;
      end else if (reg_tick) begin
        if (bus.mode == 2'b00) begin
          reg_q[i] <= reg_q[i] + REG_W'(i + 1);
        end else if (bus.mode == 2'b01) begin
          reg_q[i] <= reg_q[i] - REG_W'(i + 1);
        end
      end
    end
  end

  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= Z_UP;
      zoom_q  <= '0;
    end else begin
      state_q <= state_d;
      zoom_q  <= zoom_d;
    end
  end

  always_comb begin
    state_d = state_q;
    zoom_d  = zoom_q;
    if (zoom_tick && !bus.zoom_hold) begin
      case (state_q)
        Z_UP: begin
          if (zoom_q < ZOOM_W'(ZOOM_MAX)) begin
            zoom_d = zoom_q + 1'b1;
          end else begin
            zoom_d  = zoom_q - 1'b1;
            state_d = Z_DOWN;
          end
        end
        default: begin
          if (zoom_q != '0) begin
            zoom_d = zoom_q - 1'b1;
          end else begin
            zoom_d  = zoom_q + 1'b1;
            state_d = Z_UP;
          end
        end
      endcase
    end
  end

  always_comb begin
    bus.registers = '0;
    for (int i = 0; i < NREG; i++) begin
      bus.registers[i*REG_W +: REG_W] = reg_q[i];
    end
  end

  assign bus.zoom      = zoom_q;
  assign bus.x_pos     = x_q;
  assign bus.y_pos     = y_q;
  assign bus.frame_cnt = fcnt_q;
  assign bus.led       = fcnt_q[FCNT_W-1];
endmodule

// File: tb/tb_reg_anim_ctl.sv
// tb/tb_reg_anim_ctl.sv - randomized bench for reg_anim_ctl against an arithmetic frame model
module tb_reg_anim_ctl;
  localparam int NREG    = 4;
  localparam int REG_W   = 16;
  localparam int POS_MAX = 639;
  localparam int STEP    = 4;
  localparam int ZMAX    = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_anim_ctl_if bus ();
  reg_anim_ctl dut (.px_clk(clk), .rst_n(rst_n), .bus(bus));

  int checks   = 0;
  int failures = 0;
  int m_fcnt, m_zsteps, m_x, m_y;
  int m_reg [NREG];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // zoom is a triangle wave over the count of taken zoom steps
  function automatic int m_zoom();
    int p;
    p = m_zsteps % (2 * ZMAX);
    return (p <= ZMAX) ? p : 2 * ZMAX - p;
  endfunction

  function automatic int sat_step(input int pos, input bit up, input bit down);
    if (up && !down)  return (pos + STEP > POS_MAX) ? POS_MAX : pos + STEP;
    if (down && !up)  return (pos < STEP) ? 0 : pos - STEP;
    return pos;
  endfunction

  task automatic model_reset();
    m_fcnt = 0; m_zsteps = 0; m_x = 0; m_y = 0;
    for (int i = 0; i < NREG; i++) m_reg[i] = 25 + i;
  endtask

  task automatic model_frame(input int md, input bit hold, input logic [3:0] b,
                             input bit ld, input int sel, input int val);
    if (m_fcnt % 16 == 15 && md < 2) begin
      for (int i = 0; i < NREG; i++)
        m_reg[i] = (md == 0) ? (m_reg[i] + i + 1) % 65536 : (m_reg[i] + 65536 - (i + 1)) % 65536;
    end
    if (m_fcnt % 128 == 127 && !hold) m_zsteps++;
    m_x = sat_step(m_x, b[0], b[1]);
    m_y = sat_step(m_y, b[2], b[3]);
    m_fcnt = (m_fcnt + 1) % 256;
    if (ld && sel < NREG) m_reg[sel] = val;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < NREG; i++)
      check($sformatf("%s_reg%0d", tag, i), 32'(bus.registers[i*REG_W +: REG_W]), m_reg[i]);
    check({tag, "_zoom"}, 32'(bus.zoom), m_zoom());
    check({tag, "_x"}, 32'(bus.x_pos), m_x);
    check({tag, "_y"}, 32'(bus.y_pos), m_y);
    check({tag, "_fcnt"}, 32'(bus.frame_cnt), m_fcnt);
    check({tag, "_led"}, 32'(bus.led), (m_fcnt >= 128) ? 1 : 0);
  endtask

  // one endframe rising edge; buttons settle through the synchroniser first
  task automatic frame(input string tag, input int md, input bit hold, input logic [3:0] b,
                       input bit ld, input int sel, input int val);
    @(negedge clk);
    bus.mode = 2'(md); bus.zoom_hold = hold; bus.btn = b;
    @(negedge clk);
    @(negedge clk);
    bus.endframe = 1'b1;
    if (ld) begin
      bus.load_en = 1'b1; bus.load_sel = 2'(sel); bus.load_val = 16'(val);
    end
    @(negedge clk);
    bus.endframe = 1'b0; bus.load_en = 1'b0;
    model_frame(md, hold, b, ld, sel, val);
    check_all(tag);
  endtask

  task automatic do_load(input int sel, input int val);
    @(negedge clk);
    bus.load_en = 1'b1; bus.load_sel = 2'(sel); bus.load_val = 16'(val);
    @(negedge clk);
    bus.load_en = 1'b0;
    m_reg[sel] = val;
    check_all("load");
  endtask

  int zseq [10] = '{1, 2, 3, 4, 3, 2, 1, 0, 1, 2};
  int k, r1, guard;

  initial begin
    bus.endframe = 1'b0; bus.mode = 2'b00; bus.zoom_hold = 1'b0; bus.load_en = 1'b0;
    bus.load_sel = '0; bus.load_val = '0; bus.btn = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    for (int f = 0; f < 16; f++) frame("t1", 0, 0, 4'b0000, 0, 0, 0);
    check("t1_fcnt", 32'(bus.frame_cnt), 16);
    check("t1_reg0", 32'(bus.registers[15:0]), 32'h001A);
    check("t1_reg3", 32'(bus.registers[63:48]), 32'h0020);

    do_load(0, 0);
    for (int f = 0; f < 16; f++) frame("t2", 1, 0, 4'b0000, 0, 0, 0);
    check("t2_dec_wrap", 32'(bus.registers[15:0]), 32'hFFFF);
    for (int f = 0; f < 16; f++) frame("t2h", 2, 0, 4'b0000, 0, 0, 0);
    check("t2_hold", 32'(bus.registers[15:0]), 32'hFFFF);

    k = 0;
    guard = 0;
    while (k < 10 && guard < 1400) begin
      frame("t3", 2, 0, 4'b0000, 0, 0, 0);
      guard++;
      if (m_fcnt % 128 == 0) begin
        check($sformatf("t3_zseq%0d", k), 32'(bus.zoom), zseq[k]);
        k++;
      end
    end
    check("t3_ticks_seen", k, 10);
    for (int f = 0; f < 200; f++) frame("t3h", 2, 1, 4'b0000, 0, 0, 0);
    check("t3_hold_zoom", 32'(bus.zoom), 2);

    for (int f = 0; f < 200; f++) frame("t4", 2, 1, 4'b0001, 0, 0, 0);
    check("t4_xmax", 32'(bus.x_pos), POS_MAX);
    for (int f = 0; f < 5; f++) frame("t4b", 2, 1, 4'b0011, 0, 0, 0);
    check("t4_both_hold", 32'(bus.x_pos), POS_MAX);
    for (int f = 0; f < 3; f++) frame("t4d", 2, 1, 4'b1010, 0, 0, 0);
    check("t4_xdown", 32'(bus.x_pos), POS_MAX - 3 * STEP);

    while (m_fcnt % 16 != 15) frame("t5a", 2, 1, 4'b0000, 0, 0, 0);
    r1 = m_reg[1];
    frame("t5", 0, 1, 4'b0000, 1, 2, 32'hBEEF);
    check("t5_reg2_load", 32'(bus.registers[47:32]), 32'hBEEF);
    check("t5_reg1_inc", 32'(bus.registers[31:16]), (r1 + 2) % 65536);

    for (int f = 0; f < 400; f++)
      frame("rnd", int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0),
            int'($urandom_range(0, NREG - 1)), int'($urandom_range(0, 65535)));

    @(negedge clk);
    bus.endframe = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("t6_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_all("t6_notick");
    bus.endframe = 1'b0;
    frame("t6_first", 2, 0, 4'b0000, 0, 0, 0);
    check("t6_fcnt1", 32'(bus.frame_cnt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
